// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths, FSM encoding and pixel helper for the SAD search block
package sad_pkg;

  localparam int SADW = 12;
  localparam int PIX  = 8;
  localparam int NPIX = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_REQ  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [PIX-1:0] abs_diff(input logic [PIX-1:0] a, input logic [PIX-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad4x4_unit.sv
// rtl/sad4x4_unit.sv - combinational 4x4 sum of absolute differences
module sad4x4_unit
  import sad_pkg::*;
(
  input  logic [NPIX*PIX-1:0] crop,
  input  logic [NPIX*PIX-1:0] window,
  output logic [SADW-1:0]     sad
);

  // Accumulate the 16 unsigned byte differences; the worst case 16*255 fits SADW
  always_comb begin
    sad = '0;
    for (int k = 0; k < NPIX; k++) begin
      sad = sad + SADW'(abs_diff(crop[k*PIX +: PIX], window[k*PIX +: PIX]));
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - full-search 4x4 block match sequencer with running minimum
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int MAX_DIM = 64,
  parameter int CW      = $clog2(MAX_DIM)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [NPIX*PIX-1:0] Crop,
  input  logic [CW:0]         FrameRows,
  input  logic [CW:0]         FrameCols,
  output logic                WinReq,
  output logic [CW-1:0]       WinRow,
  output logic [CW-1:0]       WinCol,
  input  logic                WinAck,
  input  logic [NPIX*PIX-1:0] Window,
  output logic                Busy,
  output logic                Done,
  output logic                DimErr,
  output logic [SADW-1:0]     BestSAD,
  output logic [CW-1:0]       BestRow,
  output logic [CW-1:0]       BestCol
);

  state_t state, next_state;

  logic [NPIX*PIX-1:0] crop_q;
  logic [NPIX*PIX-1:0] win_q;
  logic [CW:0]         rows_q;
  logic [CW:0]         cols_q;
  logic [CW-1:0]       row;
  logic [CW-1:0]       col;
  logic [SADW-1:0]     sad;

  logic start_acc;
  logic win_take;
  logic cmp_en;
  logic dim_bad;
  logic row_last;
  logic col_last;
  logic last_pos;

  assign dim_bad  = (rows_q < (CW+1)'(4)) || (cols_q < (CW+1)'(4));
  assign row_last = ({1'b0, row} == rows_q - (CW+1)'(4));
  assign col_last = ({1'b0, col} == cols_q - (CW+1)'(4));
  assign last_pos = row_last && col_last;

  assign WinRow = row;
  assign WinCol = col;
  assign Busy   = (state != S_IDLE);

  sad4x4_unit u_sad (
    .crop   (crop_q),
    .window (win_q),
    .sad    (sad)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus the strobes that steer the datapath
  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    win_take   = 1'b0;
    cmp_en     = 1'b0;
    WinReq     = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          start_acc  = 1'b1;
          next_state = S_CHK;
        end
      end
      S_CHK: begin
        next_state = dim_bad ? S_DONE : S_REQ;
      end
      S_REQ: begin
        WinReq = 1'b1;
        if (WinAck) begin
          win_take   = 1'b1;
          next_state = S_CMP;
        end
      end
      S_CMP: begin
        cmp_en     = 1'b1;
        next_state = last_pos ? S_DONE : S_REQ;
      end
      S_DONE: begin
        Done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latches, raster counters and minimum tracker; ties keep the earlier position
  always_ff @(posedge Clk) begin
    if (Reset) begin
      crop_q  <= '0;
      win_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row     <= '0;
      col     <= '0;
      BestSAD <= '1;
      BestRow <= '0;
      BestCol <= '0;
      DimErr  <= 1'b0;
    end else begin
      if (start_acc) begin
        crop_q  <= Crop;
        rows_q  <= FrameRows;
        cols_q  <= FrameCols;
        row     <= '0;
        col     <= '0;
        BestSAD <= '1;
        BestRow <= '0;
        BestCol <= '0;
        DimErr  <= 1'b0;
      end
      if (state == S_CHK && dim_bad) begin
        DimErr <= 1'b1;
      end
      if (win_take) begin
        win_q <= Window;
      end
      if (cmp_en) begin
        if (sad < BestSAD) begin
          BestSAD <= sad;
          BestRow <= row;
          BestCol <= col;
        end
        if (!last_pos) begin
          if (col_last) begin
            col <= '0;
            row <= row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - scoreboard bench for sad_search_ctrl
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int CW     = 6;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [127:0]  crop;
  logic [CW:0]   frame_rows;
  logic [CW:0]   frame_cols;
  logic          win_req;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_ack;
  logic [127:0]  window;
  logic          busy;
  logic          done;
  logic          dim_err;
  logic [11:0]   best_sad;
  logic [CW-1:0] best_row;
  logic [CW-1:0] best_col;

  always #5 clk = ~clk;

  sad_search_ctrl #(.MAX_DIM(64), .CW(CW)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .Crop      (crop),
    .FrameRows (frame_rows),
    .FrameCols (frame_cols),
    .WinReq    (win_req),
    .WinRow    (win_row),
    .WinCol    (win_col),
    .WinAck    (win_ack),
    .Window    (window),
    .Busy      (busy),
    .Done      (done),
    .DimErr    (dim_err),
    .BestSAD   (best_sad),
    .BestRow   (best_row),
    .BestCol   (best_col)
  );

  typedef struct {
    int sad;
    int row;
    int col;
    bit dimerr;
  } res_t;

  res_t exp_res_q[$];
  int   exp_pos_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] crop_v;
  int mode;
  int mr;
  int mc;

  logic [11:0]   obs_sad;
  logic [CW-1:0] obs_row;
  logic [CW-1:0] obs_col;
  logic          obs_dim;

  int nreq;
  bit done_seen;
  int done_cycles;
  bit pos_err;
  bit stable_err;
  bit abort_ok;

  function automatic logic [127:0] window_for(input int r, input int c);
    logic [127:0] w;
    int off;
    for (int k = 0; k < 16; k++) begin
      if (mode == 1) off = (k == 15) ? 81 : 76;
      else if (r == mr && c == mc) off = 0;
      else off = 1 + ((r * 8 + c) % 7);
      if (k % 2 == 1) w[k*8 +: 8] = 8'(100 + k + off);
      else            w[k*8 +: 8] = 8'(100 + k - off);
    end
    return w;
  endfunction

  function automatic int model_sad(input logic [127:0] a, input logic [127:0] b);
    int s = 0;
    int d;
    for (int k = 0; k < 16; k++) begin
      d = int'(a[k*8 +: 8]) - int'(b[k*8 +: 8]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  task automatic push_expected(input int rows, input int cols);
    res_t e;
    int s;
    e.sad = 4095; e.row = 0; e.col = 0; e.dimerr = 1'b0;
    if (rows < 4 || cols < 4) begin
      e.dimerr = 1'b1;
    end else begin
      for (int r = 0; r <= rows - 4; r++) begin
        for (int c = 0; c <= cols - 4; c++) begin
          exp_pos_q.push_back(r * 64 + c);
          s = model_sad(crop_v, window_for(r, c));
          if (s < e.sad) begin
            e.sad = s; e.row = r; e.col = c;
          end
        end
      end
    end
    exp_res_q.push_back(e);
  endtask

  task automatic run_search(input int rows, input int cols, input int max_delay,
                            input int abort_at, input int busy_start_at);
    int cyc;
    int dly;
    int p;
    int hr;
    int hc;
    bit waiting;
    bit busy_done;
    nreq = 0; done_seen = 0; done_cycles = 0; pos_err = 0; stable_err = 0; abort_ok = 0;
    waiting = 0; busy_done = 0; dly = 0; hr = 0; hc = 0;
    for (int k = 0; k < 16; k++) crop_v[k*8 +: 8] = 8'(100 + k);
    crop = crop_v;
    frame_rows = 7'(rows);
    frame_cols = 7'(cols);
    push_expected(rows, cols);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc <= BUDGET) begin
      if (done) begin
        done_seen = 1; done_cycles = cyc;
        obs_sad = best_sad; obs_row = best_row; obs_col = best_col; obs_dim = dim_err;
        win_ack = 1'b0;
        break;
      end
      if (win_req) begin
        if (!waiting) begin
          nreq++;
          if (abort_at > 0 && nreq == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            win_ack = 1'b0;
            abort_ok = (busy === 1'b0) && (win_req === 1'b0);
            exp_pos_q.delete();
            exp_res_q.delete();
            repeat (20) begin
              @(negedge clk);
              if (done !== 1'b0) abort_ok = 0;
            end
            return;
          end
          if (exp_pos_q.size() == 0) pos_err = 1;
          else begin
            p = exp_pos_q.pop_front();
            if (p != int'(win_row) * 64 + int'(win_col)) pos_err = 1;
          end
          hr = int'(win_row); hc = int'(win_col);
          dly = $urandom_range(0, max_delay);
          waiting = 1;
        end else if (int'(win_row) != hr || int'(win_col) != hc) begin
          stable_err = 1;
        end
        if (dly == 0) begin
          win_ack = 1'b1;
          window = window_for(int'(win_row), int'(win_col));
          waiting = 0;
        end else begin
          win_ack = 1'b0;
          dly--;
        end
      end else begin
        win_ack = 1'b0;
      end
      if (busy_start_at > 0 && nreq == busy_start_at && !busy_done) begin
        start = 1'b1; busy_done = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; win_ack = 1'b0; window = '0; crop = '0;
    frame_rows = '0; frame_cols = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({win_req, busy, done, dim_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl got %b want 0000", {win_req, busy, done, dim_err});
    end
    n_cmp++;
    if (best_sad !== 12'hFFF) begin
      n_bad++; $display("FAIL reset_best_sad got %h want fff", best_sad);
    end
    n_cmp++;
    if ({best_row, best_col} !== 12'h000) begin
      n_bad++; $display("FAIL reset_best_pos got %0d,%0d want 0,0", best_row, best_col);
    end
  endtask

  task automatic check_result(input string name, input int want_req);
    res_t e;
    n_cmp++;
    if (done_seen !== 1'b1) begin
      n_bad++; $display("FAIL %s_done got %0d want 1 (timeout)", name, done_seen);
    end
    n_cmp++;
    if (nreq != want_req) begin
      n_bad++; $display("FAIL %s_nreq got %0d want %0d", name, nreq, want_req);
    end
    n_cmp++;
    if ({pos_err, stable_err} !== 2'b00 || exp_pos_q.size() != 0) begin
      n_bad++; $display("FAIL %s_positions got err=%b left=%0d want 00/0", name, {pos_err, stable_err}, exp_pos_q.size());
    end
    n_cmp++;
    if (exp_res_q.size() == 0) begin
      n_bad++; $display("FAIL %s_scoreboard got empty want one result", name);
    end else begin
      e = exp_res_q.pop_front();
      if (obs_sad !== 12'(e.sad) || obs_row !== 6'(e.row) || obs_col !== 6'(e.col) || obs_dim !== e.dimerr) begin
        n_bad++;
        $display("FAIL %s_result got sad=%0d (%0d,%0d) dim=%0d want sad=%0d (%0d,%0d) dim=%0d",
                 name, obs_sad, obs_row, obs_col, obs_dim, e.sad, e.row, e.col, e.dimerr);
      end
    end
  endtask

  task automatic test_exact_match();
    mode = 0; mr = 2; mc = 3;
    run_search(8, 8, 0, 0, 0);
    check_result("exact", 25);
    n_cmp++;
    if (obs_sad !== 12'd0 || obs_row !== 6'd2 || obs_col !== 6'd3) begin
      n_bad++; $display("FAIL exact_zero got sad=%0d (%0d,%0d) want 0 (2,3)", obs_sad, obs_row, obs_col);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL exact_done_pulse got %b want 0", done);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (best_sad !== 12'd0 || best_row !== 6'd2 || best_col !== 6'd3 || busy !== 1'b0) begin
      n_bad++; $display("FAIL exact_hold got sad=%0d (%0d,%0d) busy=%b want 0 (2,3) 0", best_sad, best_row, best_col, busy);
    end
  endtask

  task automatic test_tie();
    mode = 1;
    run_search(5, 7, 1, 0, 0);
    check_result("tie", 8);
    n_cmp++;
    if (obs_sad !== 12'd1221 || obs_row !== 6'd0 || obs_col !== 6'd0) begin
      n_bad++; $display("FAIL tie_first got sad=%0d (%0d,%0d) want 1221 (0,0)", obs_sad, obs_row, obs_col);
    end
  endtask

  task automatic test_dim_err();
    mode = 0; mr = 0; mc = 0;
    run_search(3, 8, 0, 0, 0);
    check_result("dim_rows", 0);
    n_cmp++;
    if (done_cycles != 2) begin
      n_bad++; $display("FAIL dim_latency got %0d want 2", done_cycles);
    end
    n_cmp++;
    if (obs_dim !== 1'b1 || obs_sad !== 12'hFFF) begin
      n_bad++; $display("FAIL dim_flags got dim=%b sad=%h want 1 fff", obs_dim, obs_sad);
    end
    run_search(8, 2, 0, 0, 0);
    check_result("dim_cols", 0);
    run_search(4, 4, 0, 0, 0);
    check_result("dim_min", 1);
  endtask

  task automatic test_ack_delay();
    mode = 0; mr = 0; mc = 1;
    for (int i = 0; i < 3; i++) begin
      run_search(4, 5, 5, 0, 0);
      check_result("ack_delay", 2);
    end
  endtask

  task automatic test_reset_abort();
    mode = 0; mr = 4; mc = 4;
    run_search(8, 8, 2, 3, 0);
    n_cmp++;
    if (abort_ok !== 1'b1) begin
      n_bad++; $display("FAIL abort_idle got %b want 1", abort_ok);
    end
    n_cmp++;
    if (best_sad !== 12'hFFF || dim_err !== 1'b0) begin
      n_bad++; $display("FAIL abort_values got sad=%h dim=%b want fff 0", best_sad, dim_err);
    end
    mode = 0; mr = 1; mc = 0;
    run_search(5, 5, 1, 0, 0);
    check_result("after_abort", 4);
  endtask

  task automatic test_busy_start();
    mode = 0; mr = 1; mc = 2;
    run_search(6, 6, 2, 0, 2);
    check_result("busy_start", 9);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || win_req !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_idle got busy=%b req=%b want 0 0", busy, win_req);
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_tie();
    test_dim_err();
    test_ack_delay();
    test_reset_abort();
    test_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
